bounce_position: RTL and testbench
==================================

// Module: bounce_position
// PURPOSE
//   Parametrised generator for the moving block's coordinate: sweeps a position back and forth
//   between 0 and a runtime right bound, stepping on qualified VGA-sync ticks. On a player drop
//   request it freezes, captures the position and hands it to the stacking logic over a valid/ready
//   handshake. Sits between the input/control FSM and the draw datapath; one instance per axis/channel.
// PARAMETERS
//   POS_W   8  position width in bits
//   STEP_W  3  step-size input width
//   DIV_W   4  tick-divider input width
// PORTS
//   clk         in   1       system clock (50 MHz); all logic on posedge clk
//   resetn      in   1       synchronous reset, active low
//   sync        in   1       one-clk pulse per VGA frame, synchronous to clk
//   enable      in   1       0 = freeze position and divider
//   restart     in   1       pulse: start a new sweep from 0, moving right
//   span_max    in   POS_W   right bound, inclusive (e.g. 104); may change at any time
//   step        in   STEP_W  pixels per move
//   div         in   DIV_W   move once every div+1 qualified sync pulses
//   drop_req    in   1       player drop request
//   drop_ready  in   1       consumer accepts drop_pos
//   curr_pos    out  POS_W   current coordinate
//   dir         out  1       0 = LEFT, 1 = RIGHT
//   moving      out  1       state == MOVE
//   drop_valid  out  1       captured position available
//   drop_pos    out  POS_W   captured position, stable while drop_valid
// BEHAVIOUR
//   Reset (resetn=0 at posedge): state IDLE; curr_pos=0, dir=RIGHT, moving=0, drop_valid=0,
//     drop_pos=0, divider=0. Reset mid-sweep or mid-handshake aborts immediately.
//   FSM IDLE -> MOVE on restart: curr_pos=0, dir=RIGHT, divider=0.
//   MOVE: move pulse = sync & enable & (divider == eff_div); divider counts qualified sync,
//     wraps to 0 on a move. curr_pos updates 1 clk after the move pulse cycle.
//     RIGHT: pos+step >= span_max -> pos=span_max, dir=LEFT; else pos+=step.
//     LEFT:  pos <= step -> pos=0, dir=RIGHT; else pos-=step. Sums in POS_W+1 bits, no wrap.
//     pos > span_max (bound shrank) -> next move sets pos=span_max, dir=LEFT.
//     span_max=0 -> pos stays 0, dir=RIGHT. step=0 -> pos holds, dir unchanged.
//     restart in MOVE re-initialises as from IDLE.
//   MOVE -> HOLD on drop_req: drop_pos=curr_pos (pre-move value; drop beats a same-cycle move
//     pulse, which is discarded); drop_valid=1 next clk. drop_req beats restart.
//   HOLD: drop_valid=1, drop_pos/curr_pos frozen; restart and drop_req ignored.
//     drop_valid & drop_ready -> IDLE, drop_valid=0 next clk. drop_ready without valid ignored.
//   drop_req in IDLE ignored.
// CONFIGURATION
//   BOUNCE_SPEED_RAMP_EN defined: each completed drop handshake increments a DIV_W-bit ramp
//     register (saturating); eff_div = div - ramp, saturating at 0. Ramp is cleared by reset
//     only, not by restart.
//   Not defined: eff_div = div; no ramp register.
// STRUCTURE
//   babel_pkg: dir_t enum (LEFT=0, RIGHT=1), state enum {IDLE, MOVE, HOLD}, default span 104.
//   Sub-module tick_divider: counts qualified sync pulses, emits move pulse at terminal count,
//     has clear input; holds count while enable=0.
//   Top level: FSM, position arithmetic, capture register, ramp logic.
// TESTING
//   span_max=104, step=1, div=0, restart: pos 0..104 over 104 syncs, then 103 with dir=LEFT;
//     back at 0 dir=RIGHT.
//   step=5, span_max=104, pos=100 moving RIGHT: next move pos=104, dir=LEFT; next move 99.
//   div=2: pos advances once per 3 sync; enable=0 for 4 syncs leaves pos and divider unchanged.
//   drop_req with sync in same cycle at pos=37: drop_pos=37, drop_valid=1 next clk; hold with
//     drop_ready=0 for 5 clk (stable); drop_ready=1 -> IDLE; restart -> pos=0.
//   pos=80, span_max changed to 60: next move pos=60, dir=LEFT; resetn=0 in HOLD -> all outputs 0.
//   BOUNCE_SPEED_RAMP_EN, div=3: after 2 drops moves every 2 sync; after 4+ drops every sync.

Source files
------------

// File: rtl/bounce_position_pkg.sv
// Shared types for the bounce_position block: sweep direction, control states, default span.
package babel_pkg;

   typedef enum logic {
      LEFT  = 1'b0,
      RIGHT = 1'b1
   } dir_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MOVE = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam int DEFAULT_SPAN = 104;

endpackage

// File: rtl/bounce_position_if.sv
// Control/handshake bundle between the input FSM, bounce_position and the stacking logic.
// drop_valid/drop_ready: the block raises drop_valid with drop_pos and holds both stable until
// the cycle drop_valid & drop_ready is seen at posedge clk; that cycle completes the transfer.
interface bounce_position_if #(
   parameter int POS_W  = 8,
   parameter int STEP_W = 3,
   parameter int DIV_W  = 4
);
   import babel_pkg::*;

   logic              sync;
   logic              enable;
   logic              restart;
   logic [POS_W-1:0]  span_max;
   logic [STEP_W-1:0] step;
   logic [DIV_W-1:0]  div;
   logic              drop_req;
   logic              drop_ready;
   logic [POS_W-1:0]  curr_pos;
   logic              dir;
   logic              moving;
   logic              drop_valid;
   logic [POS_W-1:0]  drop_pos;
   state_t            dbg_state;

   modport master (
      output sync, enable, restart, span_max, step, div, drop_req, drop_ready,
      input  curr_pos, dir, moving, drop_valid, drop_pos, dbg_state
   );

   modport slave (
      input  sync, enable, restart, span_max, step, div, drop_req, drop_ready,
      output curr_pos, dir, moving, drop_valid, drop_pos, dbg_state
   );

endinterface

// File: rtl/bounce_position_tick_divider.sv
// Counts qualified sync pulses and emits a one-cycle move pulse every term+1 of them.
module tick_divider #(
   parameter int DIV_W = 4
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             sync,
   input  logic             enable,
   input  logic             clear,
   input  logic [DIV_W-1:0] term,
   output logic             move
);

   logic [DIV_W-1:0] count_q, count_d;
   logic             qual;

   assign qual = sync & enable;
   // >= so a terminal count lowered below the running count still fires promptly.
   assign move = qual & (count_q >= term);

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (move) begin
         count_d = '0;
      end else if (qual) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/bounce_position.sv
// Bouncing block coordinate with drop capture handshake.
// Optional BOUNCE_SPEED_RAMP_EN: each completed drop shortens the move interval (saturating).
module bounce_position
   import babel_pkg::*;
#(
   parameter int POS_W  = 8,
   parameter int STEP_W = 3,
   parameter int DIV_W  = 4
) (
   input  logic              clk,
   input  logic              resetn,
   bounce_position_if.slave  bus
);

   state_t           state_q, state_d;
   logic [POS_W-1:0] pos_q, pos_d;
   dir_t             dir_q, dir_d;
   logic             drop_valid_q, drop_valid_d;
   logic [POS_W-1:0] drop_pos_q, drop_pos_d;
   logic             clear_div;
   logic             move;
   logic [DIV_W-1:0] eff_div;

   logic [POS_W-1:0] step_n;
   logic [POS_W:0]   pos_ext, step_ext, span_ext, sum;
   logic [POS_W-1:0] diff;
   logic [POS_W-1:0] step_pos;
   dir_t             step_dir;

`ifdef BOUNCE_SPEED_RAMP_EN
   logic [DIV_W-1:0] ramp_q, ramp_d;
   assign eff_div = (bus.div > ramp_q) ? (bus.div - ramp_q) : '0;
`else
   assign eff_div = bus.div;
`endif

   tick_divider #(.DIV_W(DIV_W)) u_div (
      .clk    (clk),
      .resetn (resetn),
      .sync   (bus.sync),
      .enable (bus.enable & (state_q == MOVE)),
      .clear  (clear_div),
      .term   (eff_div),
      .move   (move)
   );

   assign step_n   = {{(POS_W-STEP_W){1'b0}}, bus.step};
   assign pos_ext  = {1'b0, pos_q};
   assign step_ext = {1'b0, step_n};
   assign span_ext = {1'b0, bus.span_max};
   assign sum      = pos_ext + step_ext;
   assign diff     = pos_q - step_n;

   // Candidate position for a move pulse; the extra sum bit keeps the bound test wrap-free.
   always_comb begin
      step_pos = pos_q;
      step_dir = dir_q;
      if (bus.span_max == '0) begin
         step_pos = '0;
         step_dir = RIGHT;
      end else if (bus.step != '0) begin
         if (pos_ext > span_ext) begin
            step_pos = bus.span_max;
            step_dir = LEFT;
         end else if (dir_q == RIGHT) begin
            if (sum >= span_ext) begin
               step_pos = bus.span_max;
               step_dir = LEFT;
            end else begin
               step_pos = sum[POS_W-1:0];
            end
         end else if (pos_ext <= step_ext) begin
            step_pos = '0;
            step_dir = RIGHT;
         end else begin
            step_pos = diff;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      pos_d        = pos_q;
      dir_d        = dir_q;
      drop_valid_d = drop_valid_q;
      drop_pos_d   = drop_pos_q;
      clear_div    = 1'b0;
`ifdef BOUNCE_SPEED_RAMP_EN
      ramp_d       = ramp_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.restart) begin
               state_d   = MOVE;
               pos_d     = '0;
               dir_d     = RIGHT;
               clear_div = 1'b1;
            end
         end
         MOVE: begin
            // Drop wins over restart and over a move pulse in the same cycle.
            if (bus.drop_req) begin
               state_d      = HOLD;
               drop_pos_d   = pos_q;
               drop_valid_d = 1'b1;
            end else if (bus.restart) begin
               pos_d     = '0;
               dir_d     = RIGHT;
               clear_div = 1'b1;
            end else if (move) begin
               pos_d = step_pos;
               dir_d = step_dir;
            end
         end
         HOLD: begin
            if (bus.drop_ready) begin
               state_d      = IDLE;
               drop_valid_d = 1'b0;
`ifdef BOUNCE_SPEED_RAMP_EN
               if (ramp_q != {DIV_W{1'b1}}) ramp_d = ramp_q + 1'b1;
`endif
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q      <= IDLE;
         pos_q        <= '0;
         dir_q        <= RIGHT;
         drop_valid_q <= 1'b0;
         drop_pos_q   <= '0;
`ifdef BOUNCE_SPEED_RAMP_EN
         ramp_q       <= '0;
`endif
      end else begin
         state_q      <= state_d;
         pos_q        <= pos_d;
         dir_q        <= dir_d;
         drop_valid_q <= drop_valid_d;
         drop_pos_q   <= drop_pos_d;
`ifdef BOUNCE_SPEED_RAMP_EN
         ramp_q       <= ramp_d;
`endif
      end
   end

   assign bus.curr_pos   = pos_q;
   assign bus.dir        = dir_q;
   assign bus.moving     = (state_q == MOVE);
   assign bus.drop_valid = drop_valid_q;
   assign bus.drop_pos   = drop_pos_q;
   assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_bounce_position.sv
// Directed bench for bounce_position: vector table for bounce arithmetic plus drop/reset sequences.
module tb_bounce_position;
   import babel_pkg::*;

   logic clk;
   logic resetn;
   int   errors;
   int   checks;

   bounce_position_if #(.POS_W(8), .STEP_W(3), .DIV_W(4)) bus ();

   bounce_position #(.POS_W(8), .STEP_W(3), .DIV_W(4)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       en;
      logic [2:0] step;
      logic [7:0] span;
      logic [7:0] exp_pos;
      logic       exp_dir;
   } vec_t;

   vec_t vecs [13];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic syncs(input int n);
      for (int i = 0; i < n; i++) begin
         bus.sync = 1'b1;
         tick();
         bus.sync = 1'b0;
      end
   endtask

   task automatic do_restart();
      bus.restart = 1'b1;
      tick();
      bus.restart = 1'b0;
   endtask

   task automatic do_drop();
      do_restart();
      bus.drop_req = 1'b1;
      tick();
      bus.drop_req = 1'b0;
      bus.drop_ready = 1'b1;
      tick();
      bus.drop_ready = 1'b0;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      vecs[0]  = '{1'b1, 3'd5, 8'd104, 8'd104, 1'b0};
      vecs[1]  = '{1'b1, 3'd5, 8'd104, 8'd99,  1'b0};
      vecs[2]  = '{1'b1, 3'd3, 8'd104, 8'd96,  1'b0};
      vecs[3]  = '{1'b1, 3'd0, 8'd104, 8'd96,  1'b0};
      vecs[4]  = '{1'b1, 3'd7, 8'd104, 8'd89,  1'b0};
      vecs[5]  = '{1'b1, 3'd7, 8'd50,  8'd50,  1'b0};
      vecs[6]  = '{1'b1, 3'd7, 8'd50,  8'd43,  1'b0};
      vecs[7]  = '{1'b1, 3'd7, 8'd0,   8'd0,   1'b1};
      vecs[8]  = '{1'b1, 3'd7, 8'd50,  8'd7,   1'b1};
      vecs[9]  = '{1'b1, 3'd7, 8'd10,  8'd10,  1'b0};
      vecs[10] = '{1'b1, 3'd7, 8'd10,  8'd3,   1'b0};
      vecs[11] = '{1'b1, 3'd7, 8'd10,  8'd0,   1'b1};
      vecs[12] = '{1'b0, 3'd7, 8'd10,  8'd0,   1'b1};

      resetn         = 1'b0;
      bus.sync       = 1'b0;
      bus.enable     = 1'b1;
      bus.restart    = 1'b0;
      bus.span_max   = 8'd104;
      bus.step       = 3'd1;
      bus.div        = 4'd0;
      bus.drop_req   = 1'b0;
      bus.drop_ready = 1'b0;
      tick();
      tick();
      chk("reset_pos", 32'(bus.curr_pos), 0);
      chk("reset_dir", 32'(bus.dir), 1);
      chk("reset_moving", 32'(bus.moving), 0);
      chk("reset_valid", 32'(bus.drop_valid), 0);
      chk("reset_drop_pos", 32'(bus.drop_pos), 0);
      resetn = 1'b1;
      tick();

      // Full sweep with step 1
      do_restart();
      chk("sweep_start_moving", 32'(bus.moving), 1);
      chk("sweep_start_pos", 32'(bus.curr_pos), 0);
      syncs(104);
      chk("sweep_right_end_pos", 32'(bus.curr_pos), 104);
      chk("sweep_right_end_dir", 32'(bus.dir), 0);
      syncs(1);
      chk("sweep_first_left_pos", 32'(bus.curr_pos), 103);
      syncs(103);
      chk("sweep_left_end_pos", 32'(bus.curr_pos), 0);
      chk("sweep_left_end_dir", 32'(bus.dir), 1);

      // Vector table starting from pos 100 moving right
      bus.step = 3'd5;
      do_restart();
      syncs(20);
      chk("table_setup_pos", 32'(bus.curr_pos), 100);
      for (int i = 0; i < 13; i++) begin
         bus.enable   = vecs[i].en;
         bus.step     = vecs[i].step;
         bus.span_max = vecs[i].span;
         syncs(1);
         chk($sformatf("vec%0d_pos", i), 32'(bus.curr_pos), 32'(vecs[i].exp_pos));
         chk($sformatf("vec%0d_dir", i), 32'(bus.dir), 32'(vecs[i].exp_dir));
      end
      bus.enable   = 1'b1;
      bus.span_max = 8'd104;
      bus.step     = 3'd1;

      // Divider and enable freeze
      bus.div = 4'd2;
      do_restart();
      syncs(2);
      chk("div2_after2", 32'(bus.curr_pos), 0);
      syncs(1);
      chk("div2_after3", 32'(bus.curr_pos), 1);
      syncs(1);
      bus.enable = 1'b0;
      syncs(4);
      chk("freeze_pos", 32'(bus.curr_pos), 1);
      bus.enable = 1'b1;
      syncs(1);
      chk("freeze_div_kept_a", 32'(bus.curr_pos), 1);
      syncs(1);
      chk("freeze_div_kept_b", 32'(bus.curr_pos), 2);
      bus.div = 4'd0;

      // Drop with a same-cycle sync, then hold
      do_restart();
      syncs(37);
      chk("pre_drop_pos", 32'(bus.curr_pos), 37);
      bus.drop_req = 1'b1;
      bus.sync     = 1'b1;
      tick();
      bus.drop_req = 1'b0;
      bus.sync     = 1'b0;
      chk("drop_valid", 32'(bus.drop_valid), 1);
      chk("drop_pos", 32'(bus.drop_pos), 37);
      chk("drop_curr_pos", 32'(bus.curr_pos), 37);
      chk("drop_not_moving", 32'(bus.moving), 0);
      for (int i = 0; i < 5; i++) begin
         bus.restart  = (i == 1);
         bus.drop_req = (i == 2);
         bus.sync     = 1'b1;
         tick();
         chk($sformatf("hold%0d_valid", i), 32'(bus.drop_valid), 1);
         chk($sformatf("hold%0d_drop_pos", i), 32'(bus.drop_pos), 37);
         chk($sformatf("hold%0d_pos", i), 32'(bus.curr_pos), 37);
      end
      bus.restart  = 1'b0;
      bus.drop_req = 1'b0;
      bus.sync     = 1'b0;
      bus.drop_ready = 1'b1;
      tick();
      chk("accept_valid", 32'(bus.drop_valid), 0);
      chk("accept_idle", 32'(bus.dbg_state), 32'(IDLE));
      bus.drop_req = 1'b1;
      tick();
      bus.drop_req   = 1'b0;
      bus.drop_ready = 1'b0;
      chk("idle_drop_ignored_valid", 32'(bus.drop_valid), 0);
      chk("idle_drop_ignored_moving", 32'(bus.moving), 0);
      do_restart();
      chk("restart_after_drop_pos", 32'(bus.curr_pos), 0);
      chk("restart_after_drop_moving", 32'(bus.moving), 1);

      // Drop wins over restart
      syncs(3);
      bus.drop_req = 1'b1;
      bus.restart  = 1'b1;
      tick();
      bus.drop_req = 1'b0;
      bus.restart  = 1'b0;
      chk("drop_vs_restart_valid", 32'(bus.drop_valid), 1);
      chk("drop_vs_restart_pos", 32'(bus.drop_pos), 3);
      bus.drop_ready = 1'b1;
      tick();
      bus.drop_ready = 1'b0;

      // Bound shrinks below current position, then reset while holding
      do_restart();
      syncs(80);
      chk("shrink_setup_pos", 32'(bus.curr_pos), 80);
      bus.span_max = 8'd60;
      syncs(1);
      chk("shrink_pos", 32'(bus.curr_pos), 60);
      chk("shrink_dir", 32'(bus.dir), 0);
      bus.drop_req = 1'b1;
      tick();
      bus.drop_req = 1'b0;
      chk("shrink_hold_valid", 32'(bus.drop_valid), 1);
      resetn = 1'b0;
      tick();
      chk("hold_reset_pos", 32'(bus.curr_pos), 0);
      chk("hold_reset_dir", 32'(bus.dir), 1);
      chk("hold_reset_moving", 32'(bus.moving), 0);
      chk("hold_reset_valid", 32'(bus.drop_valid), 0);
      chk("hold_reset_drop_pos", 32'(bus.drop_pos), 0);
      resetn = 1'b1;
      bus.span_max = 8'd104;
      tick();

      // Move interval after completed drops (ramp build shortens it)
      bus.div = 4'd3;
      do_drop();
      do_drop();
      do_restart();
`ifdef BOUNCE_SPEED_RAMP_EN
      syncs(1);
      chk("ramp2_a", 32'(bus.curr_pos), 0);
      syncs(1);
      chk("ramp2_b", 32'(bus.curr_pos), 1);
`else
      syncs(3);
      chk("noramp2_a", 32'(bus.curr_pos), 0);
      syncs(1);
      chk("noramp2_b", 32'(bus.curr_pos), 1);
`endif
      do_drop();
      do_drop();
      do_restart();
`ifdef BOUNCE_SPEED_RAMP_EN
      syncs(1);
      chk("ramp4_a", 32'(bus.curr_pos), 1);
      syncs(1);
      chk("ramp4_b", 32'(bus.curr_pos), 2);
`else
      syncs(3);
      chk("noramp4_a", 32'(bus.curr_pos), 0);
      syncs(1);
      chk("noramp4_b", 32'(bus.curr_pos), 1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
